// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480 timing constants, 12-bit colour type and palette.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;

  // Width of a timing-generator coordinate; must hold the larger total.
  localparam int COORD_W = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t RGB_BLACK      = 12'h000;
  localparam rgb12_t RGB_PEAK       = 12'hF00;
  localparam rgb12_t RGB_TICK       = 12'hFFF;
  localparam rgb12_t RGB_BAR_OK     = 12'h0F0;
  localparam rgb12_t RGB_BAR_ALERT  = 12'hFF0;
  localparam rgb12_t RGB_BACKGROUND = 12'h002;

endpackage

// File: rtl/peak_hold.sv
// Peak-hold tracker: jumps up to any taller displayed value, then decays by
// one pixel every PEAK_DECAY_FRAMES frames but never below the current value.
module peak_hold #(
  parameter int PEAK_DECAY_FRAMES = 30
) (
  input  logic       vga_clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [8:0] d_next,
  output logic [8:0] peak
);

  localparam int CNT_W = (PEAK_DECAY_FRAMES > 1) ? $clog2(PEAK_DECAY_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(PEAK_DECAY_FRAMES - 1);

  logic [CNT_W-1:0] decay_count;

  // Update peak and decay counter once per frame boundary.
  always_ff @(posedge vga_clock) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      peak        <= '0;
      decay_count <= '0;
    end else if (frame_tick) begin
      if (d_next > peak) begin
        peak        <= d_next;
        decay_count <= '0;
      end else if (decay_count == LAST_FRAME) begin
        decay_count <= '0;
        if (peak > d_next) peak <= peak - 9'd1;
      end else begin
        decay_count <= decay_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/height_bar_renderer.sv
// Draws a vertical height bar with scale ticks and a decaying peak marker on
// a 640x480 VGA stream. New samples only take effect at the frame boundary.
module height_bar_renderer
  import vga_pkg::*;
#(
  parameter int BAR_LEFT          = 280,
  parameter int BAR_WIDTH         = 80,
  parameter int BASELINE          = 459,
  parameter int MAX_HEIGHT        = 400,
  parameter int ALERT_HEIGHT      = 300,
  parameter int PEAK_DECAY_FRAMES = 30
) (
  input  logic               vga_clock,
  input  logic               reset,
  input  logic [COORD_W-1:0] vga_col,
  input  logic [COORD_W-1:0] vga_row,
  input  logic               vga_valid,
  input  logic               h_sync,
  input  logic               v_sync,
  input  logic [8:0]         height_cm,
  input  logic               height_valid,
  output logic               height_ready,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               h_sync_out,
  output logic               v_sync_out,
  output logic               valid_out
);

  localparam logic [COORD_W-1:0] BOUNDARY_ROW = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] BASE_ROW     = COORD_W'(BASELINE);
  localparam logic [COORD_W-1:0] BAR_FIRST    = COORD_W'(BAR_LEFT);
  localparam logic [COORD_W-1:0] BAR_LAST     = COORD_W'(BAR_LEFT + BAR_WIDTH - 1);
  localparam logic [COORD_W-1:0] TICK_FIRST   = COORD_W'(BAR_LEFT - 16);
  localparam logic [COORD_W-1:0] TICK_LAST    = COORD_W'(BAR_LEFT - 1);
  localparam logic [8:0]         CLAMP        = 9'(MAX_HEIGHT);
  localparam logic [8:0]         ALERT        = 9'(ALERT_HEIGHT);

  logic       pending_valid;
  logic [8:0] pending_value;
  logic [8:0] displayed;
  logic [8:0] peak;
  logic [8:0] d_next;
  logic [8:0] clamped;
  logic       frame_boundary;

  assign frame_boundary = (vga_row == BOUNDARY_ROW) && (vga_col == '0);
  assign height_ready   = ~pending_valid;
  assign clamped        = (height_cm > CLAMP) ? CLAMP : height_cm;
  assign d_next         = (frame_boundary && pending_valid) ? pending_value : displayed;

  // One-entry holding register; displayed only changes at the frame boundary.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      pending_valid <= 1'b0;
      pending_value <= '0;
      displayed     <= '0;
    end else if (frame_boundary && pending_valid) begin
      displayed     <= pending_value;
      pending_valid <= 1'b0;
    end else if (height_valid && height_ready) begin
      pending_value <= clamped;
      pending_valid <= 1'b1;
    end
  end

  peak_hold #(
    .PEAK_DECAY_FRAMES(PEAK_DECAY_FRAMES)
  ) u_peak_hold (
    .vga_clock (vga_clock),
    .reset     (reset),
    .frame_tick(frame_boundary),
    .d_next    (d_next),
    .peak      (peak)
  );

  // Stage 1: register pixel coordinates and syncs.
  logic [COORD_W-1:0] s1_col;
  logic [COORD_W-1:0] s1_row;
  logic               s1_valid;
  logic               s1_hs;
  logic               s1_vs;

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      s1_col   <= '0;
      s1_row   <= '0;
      s1_valid <= 1'b0;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
    end else begin
      s1_col   <= vga_col;
      s1_row   <= vga_row;
      s1_valid <= vga_valid;
      s1_hs    <= h_sync;
      s1_vs    <= v_sync;
    end
  end

  // Pixel classification for the stage-1 coordinate, in priority order.
  logic [COORD_W-1:0] disp_w;
  logic [COORD_W-1:0] peak_w;
  logic [COORD_W-1:0] bar_top;
  logic               in_bar_cols;
  logic               in_tick_cols;
  logic               tick_row;
  logic               peak_hit;
  logic               bar_hit;
  rgb12_t             pixel_rgb;

  assign disp_w       = COORD_W'(displayed);
  assign peak_w       = COORD_W'(peak);
  assign bar_top      = COORD_W'(BASELINE + 1) - disp_w;
  assign in_bar_cols  = (s1_col >= BAR_FIRST) && (s1_col <= BAR_LAST);
  assign in_tick_cols = (s1_col >= TICK_FIRST) && (s1_col <= TICK_LAST);
  assign peak_hit     = (peak != '0) && (s1_row == BASE_ROW - peak_w) && in_bar_cols;
  assign bar_hit      = (displayed != '0) && (s1_row >= bar_top) && (s1_row <= BASE_ROW)
                        && in_bar_cols;

  always_comb begin
    // NOTE: give every always_comb output a default first so no path can
    // leave it unassigned and infer a latch.
    tick_row = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (BASELINE - 50 * k >= 0 && s1_row == COORD_W'(BASELINE - 50 * k)) tick_row = 1'b1;
    end
  end

  always_comb begin
    pixel_rgb = RGB_BACKGROUND;
    if (peak_hit)                       pixel_rgb = RGB_PEAK;
    else if (in_tick_cols && tick_row)  pixel_rgb = RGB_TICK;
    else if (bar_hit)                   pixel_rgb = (displayed < ALERT) ? RGB_BAR_OK : RGB_BAR_ALERT;
  end

  // Stage 2: registered colour and delayed syncs.
  rgb12_t rgb_q;

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      rgb_q      <= RGB_BLACK;
      h_sync_out <= 1'b1;
      v_sync_out <= 1'b1;
      valid_out  <= 1'b0;
    end else begin
      rgb_q      <= s1_valid ? pixel_rgb : RGB_BLACK;
      h_sync_out <= s1_hs;
      v_sync_out <= s1_vs;
      valid_out  <= s1_valid;
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

endmodule
